// File: rtl/isp_loader.sv
// In-system-programming loader: parses a framed byte stream into little-endian
// 32-bit words and writes them to the instruction BRAM while holding the core in reset.
module isp_loader #(
  parameter int         RAM_DEPTH = 65536,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  // Same width the BRAM derives from clogb2(RAM_DEPTH-1) for any depth >= 2
  localparam int        AW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wen,
  output logic [31:0]   din,
  output logic [AW-1:0] waddr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          hold_cpu
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic          w_accept;
  logic [15:0]   w_lenIn;
  logic [AW:0]   w_wordCntInc;
  logic          w_rxReadyNext;
  logic          w_holdNext;

  logic [7:0]    r_lenLo;
  logic [15:0]   r_len;
  logic [AW:0]   r_wordCnt;
  logic [1:0]    r_lane;
  logic [23:0]   r_word;
  logic [7:0]    r_csum;

  logic          r_rxReady;
  logic          r_busy;
  logic          r_hold;
  logic          r_done;
  logic          r_err;
  logic          r_wen;
  logic [31:0]   r_din;
  logic [AW-1:0] r_waddr;

  assign w_accept     = rx_valid && r_rxReady;
  assign w_lenIn      = {rx_data, r_lenLo};
  assign w_wordCntInc = r_wordCnt + (AW+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState   = r_state;
    w_rxReadyNext = 1'b0;
    w_holdNext    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_nextState = S_SYNC;
      S_SYNC: if (w_accept && rx_data == SYNC_BYTE) w_nextState = S_LEN0;
      S_LEN0: if (w_accept) w_nextState = S_LEN1;
      S_LEN1: begin
        if (w_accept) begin
          if (32'(w_lenIn) > 32'(RAM_DEPTH)) w_nextState = S_ERR;
          else if (w_lenIn == 16'd0)         w_nextState = S_CSUM;
          else                               w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && r_lane == 2'd3 && 32'(w_wordCntInc) == 32'(r_len))
          w_nextState = S_CSUM;
      end
      S_CSUM: if (w_accept) w_nextState = (rx_data == r_csum) ? S_DONE : S_ERR;
      default: w_nextState = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they change with it
    case (w_nextState)
      S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
        w_rxReadyNext = 1'b1;
        w_holdNext    = 1'b1;
      end
      S_ERR:   w_holdNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lenLo   <= '0;
      r_len     <= '0;
      r_wordCnt <= '0;
      r_lane    <= '0;
      r_word    <= '0;
      r_csum    <= '0;
      r_rxReady <= 1'b0;
      r_busy    <= 1'b0;
      r_hold    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wen     <= 1'b0;
      r_din     <= '0;
      r_waddr   <= '0;
    end else begin
      r_rxReady <= w_rxReadyNext;
      r_busy    <= w_rxReadyNext;
      r_hold    <= w_holdNext;
      r_done    <= (w_nextState == S_DONE);
      r_err     <= (w_nextState == S_ERR);
      r_wen     <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_wordCnt <= '0;
            r_lane    <= '0;
            r_csum    <= '0;
          end
        end
        S_LEN0: if (w_accept) r_lenLo <= rx_data;
        S_LEN1: if (w_accept) r_len <= w_lenIn;
        S_DATA: begin
          if (w_accept) begin
            r_csum <= r_csum ^ rx_data;
            // The fourth byte goes straight to din; lanes 0..2 wait in r_word
            if (r_lane == 2'd3) begin
              r_wen     <= 1'b1;
              r_din     <= {rx_data, r_word};
              r_waddr   <= r_wordCnt[AW-1:0];
              r_wordCnt <= w_wordCntInc;
              r_lane    <= 2'd0;
            end else begin
              r_word[{r_lane, 3'b000} +: 8] <= rx_data;
              r_lane <= r_lane + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready = r_rxReady;
  assign busy     = r_busy;
  assign hold_cpu = r_hold;
  assign done     = r_done;
  assign err      = r_err;
  assign wen      = r_wen;
  assign din      = r_din;
  assign waddr    = r_waddr;

endmodule

// File: doc/isp_loader.md
# isp_loader

In-system-programming loader that sits directly upstream of the instruction BRAM's write port. It accepts a framed byte stream (typically from the debug UART receiver) and assembles little-endian 32-bit instruction words. It then drives one-cycle `wen`/`din`/address writes into the BRAM and holds the core in reset for the whole download.

## Interface
- `RAM_DEPTH`, 65536: BRAM depth in words. Address width `AW = clogb2(RAM_DEPTH-1)`, using the same ceil-log2 definition as the BRAM.
- `SYNC_BYTE`, 8'hA5: frame header byte.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms the loader.
- `rx_valid` in 1: byte valid.
- `rx_data` in 8: byte payload.
- `rx_ready` out 1: byte accepted when `rx_valid && rx_ready`.
- `wen` out 1: BRAM write strobe, one cycle per word.
- `din` out 32: BRAM write data.
- `waddr` out AW: BRAM word address (drives the BRAM `addrb`).
- `busy` out 1: frame in progress.
- `done` out 1: frame loaded and checksum good (level).
- `err` out 1: frame failed (level).
- `hold_cpu` out 1: holds the core in reset while high.

## Operation
- Frame format: `SYNC_BYTE`, then `LEN[7:0]`, then `LEN[15:8]` (word count), then 4×LEN data bytes, then one checksum byte.
  - Data bytes arrive LSB first per word.
  - Checksum is the XOR of all data bytes. Initial value is 8'h00.
- States: IDLE, SYNC, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE / DONE / ERR, on `start`: go to SYNC; clear `done`, `err`, word counter, byte lane and checksum. `start` in any other state is ignored.
- SYNC: an accepted byte equal to `SYNC_BYTE` moves to LEN0. Any other byte is discarded and the state stays SYNC.
- LEN0: latch the low byte; go to LEN1.
- LEN1: latch the high byte; the next state depends on the 16-bit LEN:
  - LEN > RAM_DEPTH: go to ERR.
  - LEN == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: each accepted byte is placed into lane `lane` (0..3) of a 32-bit shift register and XORed into the checksum.
  - On lane 3: issue a write, reset the lane to 0, and increment the word counter.
  - When the word counter reaches LEN: go to CSUM.
- CSUM: on an accepted byte, go to DONE if it equals the checksum, else ERR.
- Write address equals the word counter value before the increment: word k is written at address k, k = 0..LEN-1.
  - The counter is AW+1 bits wide, so LEN == RAM_DEPTH is legal and no wrap occurs.
- Outputs by state:
  - `rx_ready` = 1 in SYNC, LEN0, LEN1, DATA and CSUM; 0 in IDLE, DONE and ERR.
  - `busy` has the same decode as `rx_ready`.
  - `hold_cpu` = 1 in SYNC through CSUM and in ERR; 0 in IDLE and DONE.
- Words already written before an ERR are not rolled back. Software must reload.

## Timing
- Reset values: state IDLE; `rx_ready`, `wen`, `busy`, `done`, `err` and `hold_cpu` all 0; `din` = 0; `waddr` = 0.
- All outputs are registered.
- Bytes may be accepted on every cycle; there is no stall inside a frame.
- Write timing:
  - `wen` is high for exactly the one cycle after the 4th byte of a word is accepted.
  - In that cycle `din = {b3,b2,b1,b0}` and `waddr = k`.
  - `din` and `waddr` hold their values until the next write.
- State-flag timing:
  - `done` or `err` rises the cycle after the deciding byte is accepted, and stays high until the next `start`.
  - `hold_cpu` falls in the same cycle `done` rises.
- A checksum byte accepted on the cycle right after the last data byte is legal. The final `wen` and the CSUM decision then overlap with no loss.
- `start` sampled high in IDLE/DONE/ERR: `rx_ready` and `hold_cpu` are high on the next cycle.
- `rst` asserted mid-frame clears everything immediately, including `wen` (a pending write is dropped).

## Test plan
- Nominal frame: A5, 02, 00, 13 00 00 00, 6F 00 00 00, checksum 7C (13^6F).
  - Two `wen` pulses: addr 0 with din 32'h00000013, then addr 1 with din 32'h0000006F.
  - `done`=1 one cycle after the checksum byte; `hold_cpu`=0; `err`=0.
- Junk before sync: bytes 00, FF, 5A, then A5 00 00 00.
  - Junk is discarded; LEN=0 goes to CSUM.
  - Checksum 00 gives `done`=1 with zero `wen` pulses.
- Bad checksum: nominal frame with checksum 7D.
  - Both writes still occur; then `err`=1, `done`=0, `hold_cpu` stays 1.
- Oversize length: RAM_DEPTH=16, frame A5, 11, 00.
  - `err`=1 the cycle after the LEN1 byte; no `wen`; `rx_ready`=0 afterwards.
- Full depth with back-to-back bytes: RAM_DEPTH=16, LEN=16, `rx_valid` held high.
  - 16 writes at addresses 0..15 with no wrap and no stall; `done`=1.
- Reset and restart: assert `rst` after the 6th byte of the nominal frame.
  - All outputs return to reset values; the partially assembled word is never written.
  - A fresh `start` plus the full frame then completes with `done`=1.
